// File: rtl/sram_sp_ctrl_if.sv
// rtl/sram_sp_ctrl_if.sv - request/response channel bundle for sram_sp_ctrl
//
// Purpose: groups the word-wide request channel and the response channel
// between a requester (master) and the SRAM controller (slave).
// Signals:
//   req_valid/req_ready   request handshake (accepted when both high)
//   req_write             1 = write, 0 = read
//   req_addr  [AW]        word address
//   req_wdata [WIDTH]     write data
//   req_wstrb [WIDTH/8]   byte enables, writes only
//   resp_valid/resp_ready response handshake
//   resp_write            response is a write ack
//   resp_rdata [WIDTH]    read data, 0 for write acks
interface sram_sp_ctrl_if #(
   parameter int AW    = 9,
   parameter int WIDTH = 56
) ();
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_write;
   logic [AW-1:0]          req_addr;
   logic [WIDTH-1:0]       req_wdata;
   logic [WIDTH/8-1:0]     req_wstrb;
   logic                   resp_valid;
   logic                   resp_ready;
   logic                   resp_write;
   logic [WIDTH-1:0]       resp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_write, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_write, resp_rdata
   );
endinterface

// File: rtl/sram_sp_ctrl.sv
// rtl/sram_sp_ctrl.sv - request-side controller for the single-port sram_sp macro
//
// Purpose: accepts one word-wide read/write request at a time, drives the
// SRAM pins, captures read data one cycle after the access and returns a
// response. Partial writes become read-modify-write because the macro only
// writes whole words. Optionally zero-fills the whole array after reset.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   bus (slave)       request / response channels (see sram_sp_ctrl_if)
//   init_done         zero-fill finished; held until the next reset
//   mem_we/addr/din   to sram_sp we/addr/din, sampled at the end of the cycle
//   mem_dout          from sram_sp dout, valid the cycle after a read access
module sram_sp_ctrl #(
   parameter int  DEPTH          = 512,
   parameter int  WIDTH          = 56,
   parameter bit  CLEAR_ON_RESET = 1'b1,
   localparam int AW             = $clog2(DEPTH),
   localparam int BYTES          = WIDTH / 8
) (
   input  logic             clk,
   input  logic             resetn,
   sram_sp_ctrl_if.slave    bus,
   output logic             init_done,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_din,
   input  logic [WIDTH-1:0] mem_dout
);

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      RD_WAIT,
      RMW_WAIT,
      RESP
   } state_t;

   state_t             state;
   logic [AW-1:0]      cnt;
   logic [AW-1:0]      addr_q;
   logic [WIDTH-1:0]   wdata_q;
   logic [BYTES-1:0]   wstrb_q;
   logic               req_ready_q;
   logic               resp_valid_q;
   logic               resp_write_q;
   logic [WIDTH-1:0]   resp_rdata_q;
   logic               init_done_q;

   logic               accept;
   logic               wstrb_full;
   logic               wstrb_none;
   logic               mem_we_c;
   logic [WIDTH-1:0]   merged;

   assign accept     = bus.req_valid & req_ready_q & (state == IDLE);
   assign wstrb_full = &bus.req_wstrb;
   assign wstrb_none = ~|bus.req_wstrb;

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_write = resp_write_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign init_done      = init_done_q;

   // Old word from the SRAM with the latched write bytes laid over it.
   always_comb begin
      merged = '0;
      for (int j = 0; j < BYTES; j++) begin
         merged[j*8 +: 8] = wstrb_q[j] ? wdata_q[j*8 +: 8] : mem_dout[j*8 +: 8];
      end
   end

   // SRAM pins. addr_q remembers the last address driven so the address bus
   // stays quiet when no access is made.
   always_comb begin
      mem_we_c = 1'b0;
      mem_addr = addr_q;
      mem_din  = '0;
      case (state)
         INIT: begin
            mem_we_c = 1'b1;
            mem_addr = cnt;
         end
         IDLE: begin
            // A zero-strobe write makes no access at all.
            if (accept && !(bus.req_write && wstrb_none)) begin
               mem_addr = bus.req_addr;
               if (bus.req_write && wstrb_full) begin
                  mem_we_c = 1'b1;
                  mem_din  = bus.req_wdata;
               end
            end
         end
         RMW_WAIT: begin
            mem_we_c = 1'b1;
            mem_din  = merged;
         end
         default: begin
         end
      endcase
   end

   // Reset must stop a write immediately, without waiting for the state
   // register to be seen by the combinational decode.
   assign mem_we = mem_we_c & resetn;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= CLEAR_ON_RESET ? INIT : IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_write_q <= 1'b0;
         resp_rdata_q <= '0;
         init_done_q  <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               cnt    <= cnt + 1'b1;
               addr_q <= cnt;
               if (cnt == AW'(DEPTH - 1)) begin
                  state       <= IDLE;
                  init_done_q <= 1'b1;
                  req_ready_q <= 1'b1;
               end
            end
            IDLE: begin
               // Covers the no-clear build, where reset lands straight here.
               init_done_q <= 1'b1;
               if (accept) begin
                  req_ready_q <= 1'b0;
                  if (!bus.req_write) begin
                     addr_q <= bus.req_addr;
                     state  <= RD_WAIT;
                  end else if (wstrb_full) begin
                     addr_q       <= bus.req_addr;
                     resp_valid_q <= 1'b1;
                     resp_write_q <= 1'b1;
                     resp_rdata_q <= '0;
                     state        <= RESP;
                  end else if (wstrb_none) begin
                     resp_valid_q <= 1'b1;
                     resp_write_q <= 1'b1;
                     resp_rdata_q <= '0;
                     state        <= RESP;
                  end else begin
                     addr_q  <= bus.req_addr;
                     wdata_q <= bus.req_wdata;
                     wstrb_q <= bus.req_wstrb;
                     state   <= RMW_WAIT;
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            RD_WAIT: begin
               resp_rdata_q <= mem_dout;
               resp_write_q <= 1'b0;
               resp_valid_q <= 1'b1;
               state        <= RESP;
            end
            RMW_WAIT: begin
               resp_rdata_q <= '0;
               resp_write_q <= 1'b1;
               resp_valid_q <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// tb/tb_sram_sp_ctrl.sv - testbench for sram_sp_ctrl with a behavioural sram_sp
module tb_sram_sp_ctrl;
   localparam int DEPTH = 512;
   localparam int WIDTH = 56;
   localparam int AW    = 9;
   localparam int BYTES = 7;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             init_done;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_din;
   logic [WIDTH-1:0] mem_dout;

   sram_sp_ctrl_if #(.AW(AW), .WIDTH(WIDTH)) bus ();

   sram_sp_ctrl #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH),
      .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .bus      (bus),
      .init_done(init_done),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   always #5 clk = ~clk;

   logic [WIDTH-1:0] sram [DEPTH];
   always @(posedge clk) begin
      if (mem_we) sram[mem_addr] <= mem_din;
      mem_dout <= sram[mem_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] shadow [DEPTH];
   logic [WIDTH:0]   exp_q [$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, observed hang required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_shadow();
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
   endtask

   task automatic wait_init(input string tag);
      int cyc = 0;
      int early = 0;
      while (!init_done && cyc < 2000) begin
         if (bus.req_ready) early++;
         tick();
         cyc++;
      end
      check({tag, "_cycles"}, cyc, 512);
      check({tag, "_ready_early"}, early, 0);
      check({tag, "_ready_after"}, bus.req_ready, 1'b1);
   endtask

   // Drives one request, records the expected response, returns in cycle T+1.
   task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                         input logic [BYTES-1:0] s, output logic we_t, output logic we_t1);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wstrb = s;
      while (!bus.req_ready && n < 2000) begin
         tick();
         n++;
      end
      check("req_accept", bus.req_ready, 1'b1);
      #1 we_t = mem_we;
      if (wr) begin
         exp_q.push_back({1'b1, {WIDTH{1'b0}}});
         for (int j = 0; j < BYTES; j++)
            if (s[j]) shadow[a][j*8 +: 8] = d[j*8 +: 8];
      end else begin
         exp_q.push_back({1'b0, shadow[a]});
      end
      tick();
      bus.req_valid = 1'b0;
      #1 we_t1 = mem_we;
   endtask

   task automatic get_resp(input int exp_lat, input string tag);
      int lat = 1;
      logic [WIDTH:0] e;
      while (!bus.resp_valid && lat < 64) begin
         tick();
         lat++;
      end
      if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_resp_write"}, bus.resp_write, e[WIDTH]);
         check({tag, "_resp_rdata"}, bus.resp_rdata, e[WIDTH-1:0]);
      end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      check({tag, "_resp_dropped"}, bus.resp_valid, 1'b0);
   endtask

   initial begin
      logic we_t, we_t1;
      logic [WIDTH-1:0] hold_rd;
      logic [WIDTH-1:0] rd;
      logic [BYTES-1:0] st;
      logic wr;
      logic [AW-1:0] ad;
      int bad;
      int n;
      int el;

      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_wstrb  = '0;
      bus.resp_ready = 1'b0;
      clear_shadow();

      // Reset state.
      repeat (3) tick();
      check("rst_req_ready", bus.req_ready, 1'b0);
      check("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_resp_write", bus.resp_write, 1'b0);
      check("rst_resp_rdata", bus.resp_rdata, '0);
      check("rst_init_done", init_done, 1'b0);
      check("rst_mem_we_gated", mem_we, 1'b0);

      // Zero-fill.
      resetn = 1'b1;
      #1;
      check("init_first_we", mem_we, 1'b1);
      check("init_first_addr", mem_addr, '0);
      wait_init("init1");

      do_req(1'b0, 9'h1FF, '0, '0, we_t, we_t1);
      check("rd_top_we_t", we_t, 1'b0);
      get_resp(2, "rd_top");

      // Full write then read back.
      do_req(1'b1, 9'd5, 56'h11223344556677, 7'h7F, we_t, we_t1);
      check("wr5_we_t", we_t, 1'b1);
      check("wr5_we_t1", we_t1, 1'b0);
      get_resp(1, "wr5");
      do_req(1'b0, 9'd5, '0, '0, we_t, we_t1);
      get_resp(2, "rd5");

      // Partial write: read-modify-write.
      do_req(1'b1, 9'd5, 56'hAAAAAAAAAAAAAA, 7'h05, we_t, we_t1);
      check("rmw_we_t", we_t, 1'b0);
      check("rmw_we_t1", we_t1, 1'b1);
      get_resp(2, "rmw");
      check("rmw_shadow_const", shadow[5], 56'h11223344AA66AA);
      do_req(1'b0, 9'd5, '0, '0, we_t, we_t1);
      get_resp(2, "rmw_rd");

      // Back-pressure on the response.
      do_req(1'b0, 9'd5, '0, '0, we_t, we_t1);
      n = 0;
      while (!bus.resp_valid && n < 64) begin
         tick();
         n++;
      end
      check("hold_valid", bus.resp_valid, 1'b1);
      hold_rd = bus.resp_rdata;
      bad = 0;
      repeat (10) begin
         tick();
         if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== hold_rd ||
             bus.req_ready !== 1'b0 || mem_we !== 1'b0) bad++;
      end
      check("hold_stable", bad, 0);
      get_resp(0, "hold");

      // Zero-strobe write leaves the word alone.
      do_req(1'b1, 9'd7, 56'h1, 7'h7F, we_t, we_t1);
      get_resp(1, "wr7");
      do_req(1'b1, 9'd7, 56'hFFFFFFFFFFFFFF, 7'h00, we_t, we_t1);
      check("z_we_t", we_t, 1'b0);
      check("z_we_t1", we_t1, 1'b0);
      get_resp(1, "zstrb");
      do_req(1'b0, 9'd7, '0, '0, we_t, we_t1);
      get_resp(2, "rd7");
      check("rd7_shadow_const", shadow[7], 56'h1);

      // Mixed traffic against the shadow model.
      for (int k = 0; k < 24; k++) begin
         wr = 1'(($urandom_range(0, 1)));
         ad = AW'($urandom_range(0, 15));
         rd = {$urandom, $urandom} & {WIDTH{1'b1}};
         st = BYTES'($urandom_range(0, 127));
         if (k % 6 == 0) st = 7'h7F;
         if (k % 6 == 1) st = 7'h00;
         el = wr ? ((st == 7'h7F || st == 7'h00) ? 1 : 2) : 2;
         do_req(wr, ad, rd, st, we_t, we_t1);
         get_resp(el, "mix");
      end

      // Reset during RMW_WAIT.
      do_req(1'b1, 9'd300, 56'hFFFFFFFFFFFFFF, 7'h10, we_t, we_t1);
      check("rmwrst_in_rmw", we_t1, 1'b1);
      resetn = 1'b0;
      #1;
      check("rmwrst_resp_valid", bus.resp_valid, 1'b0);
      check("rmwrst_mem_we", mem_we, 1'b0);
      check("rmwrst_init_done", init_done, 1'b0);
      exp_q.delete();
      clear_shadow();
      tick();
      tick();
      resetn = 1'b1;
      #1;
      check("rmwrst_restart_addr", mem_addr, '0);
      check("rmwrst_restart_we", mem_we, 1'b1);
      wait_init("init2");
      do_req(1'b0, 9'd300, '0, '0, we_t, we_t1);
      get_resp(2, "rd300");
      do_req(1'b0, 9'd5, '0, '0, we_t, we_t1);
      get_resp(2, "rd5_cleared");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
